a2d_intf: RTL and testbench

- Producer side of the load-cell/sensor interface consumed by the steering-enable and balance logic.
- Contains a 16-bit SPI master for a 12-bit, 8-channel A2D converter.
- On each `nxt` pulse it converts the next channel in a fixed round-robin (left load cell, right load cell, steer pot, battery) and holds the result in a dedicated 12-bit output register.
- Results stay stable between updates, so downstream logic can treat the outputs as static.

---
 rtl/a2d_intf_if.sv | 24 ++
 rtl/a2d_intf.sv | 172 +++++++++++++++++
 tb/tb_a2d_intf.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/a2d_intf_if.sv
// Bundles the conversion request, result registers and SPI pins of the A2D interface.
interface a2d_intf_if;
  logic        nxt;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] steer_pot;
  logic [11:0] batt;
  logic        cnv_cmplt;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  // master: the converter front end; slave: its consumer and the A2D chip
  modport master (
    input  nxt, MISO,
    output lft_ld, rght_ld, steer_pot, batt, cnv_cmplt, SS_n, SCLK, MOSI
  );

  modport slave (
    output nxt, MISO,
    input  lft_ld, rght_ld, steer_pot, batt, cnv_cmplt, SS_n, SCLK, MOSI
  );
endinterface

// File: rtl/a2d_intf.sv
// Round-robin A2D sampler: two 16-bit SPI transactions per nxt pulse
// (command, then readback) and a 12-bit result register per channel.
module a2d_intf #(
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  a2d_intf_if.master  bus
);

  localparam int unsigned H     = SCLK_DIV / 2;
  localparam int unsigned PW    = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned BW    = 5;
  localparam int unsigned NBITS = 16;

  typedef enum logic [2:0] {IDLE, TX1, GAP, TX2, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ph_q, ph_d, ph_inc;
  logic [BW-1:0] bc_q, bc_d, bc_inc;
  logic [15:0]   tx_q, tx_d;
  // Only the last 12 of the 16 received bits survive; the upper nibble shifts out.
  logic [11:0]   rx_q, rx_d;
  logic [1:0]    idx_q, idx_d;
  logic [11:0]   lft_q, lft_d, rght_q, rght_d, steer_q, steer_d, batt_q, batt_d;
  logic          ss_q, ss_d, sclk_q, sclk_d, cnv_q, cnv_d;
  logic [2:0]    ch;
  logic          xfer_end;

  // Round-robin index to A2D channel number
  always_comb begin
    unique case (idx_q)
      2'd0:    ch = 3'd0;
      2'd1:    ch = 3'd4;
      2'd2:    ch = 3'd5;
      default: ch = 3'd6;
    endcase
  end

  // Position within the transaction one clk ahead: phase inside an SCLK period and period count
  always_comb begin
    if (ph_q == PW'(SCLK_DIV - 1)) begin
      ph_inc = '0;
      bc_inc = bc_q + BW'(1);
    end else begin
      ph_inc = ph_q + PW'(1);
      bc_inc = bc_q;
    end
    xfer_end = (bc_q == BW'(NBITS)) && (ph_q == PW'(H - 1));
  end

  // State register and all output/datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= '0;
      bc_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      idx_q   <= '0;
      lft_q   <= '0;
      rght_q  <= '0;
      steer_q <= '0;
      batt_q  <= '0;
      ss_q    <= 1'b1;
      sclk_q  <= 1'b1;
      cnv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bc_q    <= bc_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      idx_q   <= idx_d;
      lft_q   <= lft_d;
      rght_q  <= rght_d;
      steer_q <= steer_d;
      batt_q  <= batt_d;
      ss_q    <= ss_d;
      sclk_q  <= sclk_d;
      cnv_q   <= cnv_d;
    end
  end

  // Next-state and next-register values; SCLK/SS_n/MOSI are computed for the following clk
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bc_d    = bc_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    idx_d   = idx_q;
    lft_d   = lft_q;
    rght_d  = rght_q;
    steer_d = steer_q;
    batt_d  = batt_q;
    ss_d    = ss_q;
    sclk_d  = sclk_q;
    cnv_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.nxt) begin
          state_d = TX1;
          ss_d    = 1'b0;
          sclk_d  = 1'b1;
          ph_d    = '0;
          bc_d    = '0;
          tx_d    = {2'b00, ch, 11'h000};
        end
      end
      TX1, TX2: begin
        if (xfer_end) begin
          ss_d   = 1'b1;
          sclk_d = 1'b1;
          ph_d   = '0;
          bc_d   = '0;
          if (state_q == TX1) begin
            state_d = GAP;
          end else begin
            state_d = DONE;
            cnv_d   = 1'b1;
            idx_d   = idx_q + 2'd1;
            unique case (idx_q)
              2'd0:    lft_d   = rx_q;
              2'd1:    rght_d  = rx_q;
              2'd2:    steer_d = rx_q;
              default: batt_d  = rx_q;
            endcase
          end
        end else begin
          ph_d   = ph_inc;
          bc_d   = bc_inc;
          sclk_d = !((ph_inc >= PW'(H)) && (bc_inc < BW'(NBITS)));
          // Falling edges after the first advance MOSI
          if ((ph_inc == PW'(H)) && (bc_inc != '0))
            tx_d = {tx_q[14:0], 1'b0};
          // Rising edges sample MISO
          if ((ph_inc == '0) && (bc_inc != '0))
            rx_d = {rx_q[10:0], bus.MISO};
        end
      end
      GAP: begin
        if (ph_q == PW'(H - 1)) begin
          state_d = TX2;
          ss_d    = 1'b0;
          ph_d    = '0;
          bc_d    = '0;
          tx_d    = '0;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.lft_ld    = lft_q;
  assign bus.rght_ld   = rght_q;
  assign bus.steer_pot = steer_q;
  assign bus.batt      = batt_q;
  assign bus.cnv_cmplt = cnv_q;
  assign bus.SS_n      = ss_q;
  assign bus.SCLK      = sclk_q;
  assign bus.MOSI      = tx_q[15];

endmodule

// File: tb/tb_a2d_intf.sv
// Directed bench for a2d_intf with a behavioural A2D slave and SPI monitor.
module tb_a2d_intf;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  a2d_intf_if bus ();

  a2d_intf #(.SCLK_DIV(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A2D model and transaction monitor state
  logic [15:0] resp [8];
  logic [15:0] words[$];
  int          lows[$];
  int          gaps[$];
  int          rises[$];
  int          cnv_cnt = 0;
  int          cnv_cyc = 0;
  int          tog     = 0;
  int          falls   = 0;
  int          t_nxt   = 0;
  logic        ss_p    = 1'b1;
  logic        sclk_p  = 1'b1;
  int          low_len = 0;
  int          hi_len  = 0;
  int          rise_n  = 0;
  logic [15:0] mosi_w  = 16'h0;
  logic [15:0] msh     = 16'h0;
  logic [2:0]  ch_last = 3'd0;

  // Sample the SPI bus mid-cycle; play the A2D by returning resp[] of the last commanded channel
  always @(negedge clk) begin
    if (bus.SCLK !== sclk_p) tog++;
    if (!bus.SS_n && ss_p) begin
      gaps.push_back(hi_len);
      falls++;
      low_len = 1;
      mosi_w  = 16'h0;
      rise_n  = 0;
      msh     = resp[ch_last];
      bus.MISO = msh[15];
    end else if (bus.SS_n && !ss_p) begin
      words.push_back(mosi_w);
      lows.push_back(low_len);
      rises.push_back(rise_n);
      ch_last = mosi_w[13:11];
      hi_len  = 1;
    end else if (!bus.SS_n) begin
      low_len++;
    end else begin
      hi_len++;
    end
    if (!bus.SS_n && bus.SCLK && !sclk_p) begin
      mosi_w = {mosi_w[14:0], bus.MOSI};
      rise_n++;
      msh = {msh[14:0], 1'b0};
      bus.MISO = msh[15];
    end
    if (bus.cnv_cmplt) begin
      cnv_cnt++;
      cnv_cyc = cyc;
    end
    ss_p   = bus.SS_n;
    sclk_p = bus.SCLK;
  end

  function automatic logic [15:0] get_word(input int i);
    if (i < words.size()) return words[i];
    return 16'hxxxx;
  endfunction

  function automatic int get_low(input int i);
    if (i < lows.size()) return lows[i];
    return -1;
  endfunction

  function automatic int get_gap(input int i);
    if (i < gaps.size()) return gaps[i];
    return -1;
  endfunction

  function automatic int get_rise(input int i);
    if (i < rises.size()) return rises[i];
    return -1;
  endfunction

  task automatic clear_mon;
    words.delete();
    lows.delete();
    gaps.delete();
    rises.delete();
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_nxt;
    @(negedge clk);
    bus.nxt = 1'b1;
    t_nxt   = cyc;
    @(negedge clk);
    bus.nxt = 1'b0;
  endtask

  task automatic wait_cnv(input int c0);
    int n = 0;
    while (cnv_cnt == c0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cnv_cnt == c0) begin
      $display("FAIL cnv_timeout: no cnv_cmplt within %0d clks", n);
      bad++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.SS_n !== 1'b1) begin $display("FAIL rst_ss_n got=%b exp=1", bus.SS_n); bad++; end
    total++; if (bus.SCLK !== 1'b1) begin $display("FAIL rst_sclk got=%b exp=1", bus.SCLK); bad++; end
    total++; if (bus.MOSI !== 1'b0) begin $display("FAIL rst_mosi got=%b exp=0", bus.MOSI); bad++; end
    total++; if (bus.cnv_cmplt !== 1'b0) begin $display("FAIL rst_cnv got=%b exp=0", bus.cnv_cmplt); bad++; end
    total++; if ({bus.lft_ld, bus.rght_ld, bus.steer_pot, bus.batt} !== 48'h0) begin
      $display("FAIL rst_results got=%h exp=0", {bus.lft_ld, bus.rght_ld, bus.steer_pot, bus.batt}); bad++; end
    rst_n = 1'b1;
    tog   = 0;
    falls = 0;
    repeat (2000) @(negedge clk);
    total++; if (falls !== 0) begin $display("FAIL idle_ss_falls got=%0d exp=0", falls); bad++; end
    total++; if (tog !== 0) begin $display("FAIL idle_sclk_toggles got=%0d exp=0", tog); bad++; end
  endtask

  task automatic test_single;
    int c0;
    resp[0] = 16'h0A5C;
    clear_mon();
    c0 = cnv_cnt;
    pulse_nxt();
    wait_cnv(c0);
    total++; if (cnv_cyc - t_nxt !== 1073) begin $display("FAIL single_latency got=%0d exp=1073", cnv_cyc - t_nxt); bad++; end
    total++; if (cnv_cnt - c0 !== 1) begin $display("FAIL single_cnv_count got=%0d exp=1", cnv_cnt - c0); bad++; end
    total++; if (get_word(0) !== 16'h0000) begin $display("FAIL single_cmd_word got=%h exp=0000", get_word(0)); bad++; end
    total++; if (get_word(1) !== 16'h0000) begin $display("FAIL single_read_word got=%h exp=0000", get_word(1)); bad++; end
    total++; if (get_low(0) !== 528) begin $display("FAIL single_ss_low1 got=%0d exp=528", get_low(0)); bad++; end
    total++; if (get_gap(1) !== 16) begin $display("FAIL single_ss_gap got=%0d exp=16", get_gap(1)); bad++; end
    total++; if (get_low(1) !== 528) begin $display("FAIL single_ss_low2 got=%0d exp=528", get_low(1)); bad++; end
    total++; if (get_rise(0) !== 16) begin $display("FAIL single_rises1 got=%0d exp=16", get_rise(0)); bad++; end
    total++; if (get_rise(1) !== 16) begin $display("FAIL single_rises2 got=%0d exp=16", get_rise(1)); bad++; end
    total++; if (bus.lft_ld !== 12'hA5C) begin $display("FAIL single_lft got=%h exp=a5c", bus.lft_ld); bad++; end
    total++; if ({bus.rght_ld, bus.steer_pot, bus.batt} !== 36'h0) begin
      $display("FAIL single_others got=%h exp=0", {bus.rght_ld, bus.steer_pot, bus.batt}); bad++; end
  endtask

  task automatic test_upper_discard;
    int c0;
    resp[4] = 16'hFABC;
    clear_mon();
    c0 = cnv_cnt;
    pulse_nxt();
    wait_cnv(c0);
    total++; if (get_word(0) !== 16'h2000) begin $display("FAIL upper_cmd got=%h exp=2000", get_word(0)); bad++; end
    total++; if (bus.rght_ld !== 12'hABC) begin $display("FAIL upper_rght got=%h exp=abc", bus.rght_ld); bad++; end
    total++; if (bus.lft_ld !== 12'hA5C) begin $display("FAIL upper_lft_hold got=%h exp=a5c", bus.lft_ld); bad++; end
  endtask

  task automatic test_busy;
    int c0;
    int t0;
    resp[5] = 16'h05A5;
    resp[6] = 16'h0C3C;
    clear_mon();
    c0 = cnv_cnt;
    pulse_nxt();
    t0 = t_nxt;
    repeat (98) @(negedge clk);
    pulse_nxt();
    while (cyc < t0 + 1073) @(negedge clk);
    bus.nxt = 1'b1;
    @(negedge clk);
    bus.nxt = 1'b0;
    repeat (1200) @(negedge clk);
    total++; if (cnv_cyc - t0 !== 1073) begin $display("FAIL busy_latency got=%0d exp=1073", cnv_cyc - t0); bad++; end
    total++; if (cnv_cnt - c0 !== 1) begin $display("FAIL busy_cnv_count got=%0d exp=1", cnv_cnt - c0); bad++; end
    total++; if (words.size() !== 2) begin $display("FAIL busy_transactions got=%0d exp=2", words.size()); bad++; end
    total++; if (get_word(0) !== 16'h2800) begin $display("FAIL busy_cmd got=%h exp=2800", get_word(0)); bad++; end
    total++; if (bus.steer_pot !== 12'h5A5) begin $display("FAIL busy_steer got=%h exp=5a5", bus.steer_pot); bad++; end
    total++; if (bus.batt !== 12'h000) begin $display("FAIL busy_batt_hold got=%h exp=000", bus.batt); bad++; end
    clear_mon();
    c0 = cnv_cnt;
    pulse_nxt();
    wait_cnv(c0);
    total++; if (get_word(0) !== 16'h3000) begin $display("FAIL busy_next_cmd got=%h exp=3000", get_word(0)); bad++; end
    total++; if (bus.batt !== 12'hC3C) begin $display("FAIL busy_next_batt got=%h exp=c3c", bus.batt); bad++; end
  endtask

  task automatic test_round;
    logic [15:0] exp_w [5];
    int c0;
    exp_w[0] = 16'h0000; exp_w[1] = 16'h2000; exp_w[2] = 16'h2800;
    exp_w[3] = 16'h3000; exp_w[4] = 16'h0000;
    do_reset();
    resp[0] = 16'h0111; resp[4] = 16'h0222; resp[5] = 16'h0333; resp[6] = 16'h0444;
    clear_mon();
    c0 = cnv_cnt;
    for (int i = 0; i < 5; i++) begin
      pulse_nxt();
      wait_cnv(c0 + i);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (get_word(2 * i) !== exp_w[i]) begin
        $display("FAIL round_cmd%0d got=%h exp=%h", i, get_word(2 * i), exp_w[i]); bad++;
      end
    end
    total++; if (cnv_cnt - c0 !== 5) begin $display("FAIL round_cnv_count got=%0d exp=5", cnv_cnt - c0); bad++; end
    total++; if ({bus.lft_ld, bus.rght_ld, bus.steer_pot, bus.batt} !== 48'h111_222_333_444) begin
      $display("FAIL round_results got=%h exp=111222333444", {bus.lft_ld, bus.rght_ld, bus.steer_pot, bus.batt}); bad++; end
  endtask

  task automatic test_midreset;
    int c0;
    do_reset();
    clear_mon();
    c0 = cnv_cnt;
    pulse_nxt();
    while (cyc < t_nxt + 1 + 528 + 16 + 300) @(negedge clk);
    total++; if (bus.SS_n !== 1'b0) begin $display("FAIL midrst_in_tx2 got=%b exp=0", bus.SS_n); bad++; end
    rst_n = 1'b0;
    #1;
    total++; if (bus.SS_n !== 1'b1) begin $display("FAIL midrst_ss_n got=%b exp=1", bus.SS_n); bad++; end
    total++; if (bus.SCLK !== 1'b1) begin $display("FAIL midrst_sclk got=%b exp=1", bus.SCLK); bad++; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (1200) @(negedge clk);
    total++; if (cnv_cnt !== c0) begin $display("FAIL midrst_no_cnv got=%0d exp=%0d", cnv_cnt, c0); bad++; end
    total++; if ({bus.lft_ld, bus.rght_ld, bus.steer_pot, bus.batt} !== 48'h0) begin
      $display("FAIL midrst_results got=%h exp=0", {bus.lft_ld, bus.rght_ld, bus.steer_pot, bus.batt}); bad++; end
    clear_mon();
    pulse_nxt();
    wait_cnv(c0);
    total++; if (get_word(0) !== 16'h0000) begin $display("FAIL midrst_next_cmd got=%h exp=0000", get_word(0)); bad++; end
    total++; if (bus.lft_ld !== 12'h111) begin $display("FAIL midrst_next_lft got=%h exp=111", bus.lft_ld); bad++; end
  endtask

  initial begin
    bus.nxt = 1'b0;
    for (int i = 0; i < 8; i++) resp[i] = 16'h0;
    test_reset();
    test_single();
    test_upper_discard();
    test_busy();
    test_round();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
